// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// The master side drives commands and observes status; the slave side is the timer itself.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 4
) ();

    // Commands toward the timer
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             pause;
    logic             auto_reload;
    logic             expired_ack;

    // Registered status from the timer
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             expired;
    logic             overrun;

    modport master (
        output load,
        output load_value,
        output start,
        output stop,
        output pause,
        output auto_reload,
        output expired_ack,
        input  count,
        input  busy,
        input  tc_pulse,
        input  expired,
        input  overrun
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  stop,
        input  pause,
        input  auto_reload,
        input  expired_ack,
        output count,
        output busy,
        output tc_pulse,
        output expired,
        output overrun
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/stop, optional auto-reload and sticky expiry/overrun flags.
// Every output comes straight from a flop; expiry is flagged in the cycle count==0 is first shown.
module countdown_timer #(
    parameter int unsigned WIDTH = 4
) (
    input logic              clk,
    input logic              clear_n,
    countdown_timer_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             tc_q;
    logic             expired_q, expired_d;
    logic             overrun_q, overrun_d;
    logic             expiry;

    // One countdown tick, shared by RUN and by PAUSED resuming
    logic [1:0]       step_state;
    logic [WIDTH-1:0] step_count;
    logic             step_expiry;

    // Start values: IDLE restarts from the current count, DONE from the reload register;
    // a same-cycle load overrides either.
    logic [WIDTH-1:0] idle_src;
    logic [WIDTH-1:0] done_src;

    assign idle_src = bus.load ? bus.load_value : count_q;
    assign done_src = bus.load ? bus.load_value : reload_q;

    // Reload register tracks every load; RUN/PAUSED only pick it up at the next reload
    always_comb begin
        reload_d = reload_q;
        if (bus.load) begin
            reload_d = bus.load_value;
        end
    end

    // Tick: at zero either reload (auto_reload sampled now) or finish; otherwise decrement.
    // Reloading a zero reload register re-presents zero, which counts as a fresh expiry.
    always_comb begin
        step_state  = StRun;
        step_count  = count_q - CountOne;
        step_expiry = 1'b0;
        if (count_q == '0) begin
            if (bus.auto_reload) begin
                step_count  = reload_q;
                step_expiry = (reload_q == '0);
            end else begin
                step_state = StDone;
                step_count = '0;
            end
        end else begin
            step_expiry = (count_q == CountOne);
        end
    end

    // Main FSM: stop beats everything in RUN/PAUSED; a zero count in RUN is resolved
    // before pause so the expiry decision is never deferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expiry  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (idle_src == '0) begin
                        state_d = StDone;
                        count_d = '0;
                        expiry  = 1'b1;
                    end else begin
                        state_d = StRun;
                        count_d = idle_src;
                    end
                end else if (bus.load) begin
                    count_d = bus.load_value;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (bus.pause && (count_q != '0)) begin
                    state_d = StPaused;
                end else begin
                    state_d = step_state;
                    count_d = step_count;
                    expiry  = step_expiry;
                end
            end
            StPaused: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (!bus.pause) begin
                    state_d = step_state;
                    count_d = step_count;
                    expiry  = step_expiry;
                end
            end
            StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    count_d = done_src;
                    expiry  = (done_src == '0);
                end else begin
                    if (bus.load) begin
                        count_d = bus.load_value;
                    end
                    if (bus.expired_ack) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sticky flags: a new expiry always wins over a same-cycle acknowledge
    always_comb begin
        expired_d = expiry | (expired_q & ~bus.expired_ack);
        overrun_d = (expiry & expired_q & ~bus.expired_ack) | (overrun_q & ~bus.expired_ack);
        busy_d    = (state_d == StRun) || (state_d == StPaused);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= StIdle;
            count_q   <= '1;
            reload_q  <= '1;
            busy_q    <= 1'b0;
            tc_q      <= 1'b0;
            expired_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            tc_q      <= expiry;
            expired_q <= expired_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.tc_pulse = tc_q;
    assign bus.expired  = expired_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (WIDTH=4): directed vector table, corner sequences,
// then random traffic against a behavioural model.
module tb_countdown_timer;

    logic clk;
    logic clear_n;

    countdown_timer_if #(.WIDTH(4)) bus ();

    countdown_timer #(.WIDTH(4)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failures;

    typedef struct packed {
        logic       load;
        logic [3:0] lv;
        logic       start;
        logic       stop;
        logic       pause;
        logic       auto_r;
        logic       ack;
        logic [3:0] c;
        logic       b;
        logic       t;
        logic       e;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: 0 idle, 1 run, 2 paused, 3 done
    int m_state;
    int m_count;
    int m_reload;
    bit m_tc;
    bit m_exp;
    bit m_ovr;

    function automatic vec_t mk(input logic load, input int lv, input logic start,
                                input logic stop, input logic pause, input logic auto_r,
                                input logic ack, input int c, input logic b, input logic t,
                                input logic e, input logic o);
        vec_t v;
        v.load = load;  v.lv = lv[3:0]; v.start = start; v.stop = stop; v.pause = pause;
        v.auto_r = auto_r; v.ack = ack; v.c = c[3:0]; v.b = b; v.t = t; v.e = e; v.o = o;
        return v;
    endfunction

    task automatic drive(input logic load, input int lv, input logic start, input logic stop,
                         input logic pause, input logic auto_r, input logic ack);
        bus.load        = load;
        bus.load_value  = lv[3:0];
        bus.start       = start;
        bus.stop        = stop;
        bus.pause       = pause;
        bus.auto_reload = auto_r;
        bus.expired_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int c, input bit b, input bit t, input bit e,
                         input bit o);
        tests++;
        if (bus.count !== c[3:0] || bus.busy !== b || bus.tc_pulse !== t ||
            bus.expired !== e || bus.overrun !== o) begin
            failures++;
            $display("FAIL %s: got count=%0d busy=%0b tc=%0b exp=%0b ovr=%0b, want count=%0d busy=%0b tc=%0b exp=%0b ovr=%0b",
                     name, bus.count, bus.busy, bus.tc_pulse, bus.expired, bus.overrun,
                     c, b, t, e, o);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_count = 15; m_reload = 15; m_tc = 0; m_exp = 0; m_ovr = 0;
    endtask

    // Reset asserted between edges; state must change without waiting for a clock
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        clear_n = 1'b0;
        #2;
        check("reset_values", 15, 0, 0, 0, 0);
        @(negedge clk);
        clear_n = 1'b1;
        model_reset();
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        int  nstate;
        int  ncount;
        int  src;
        bit  evt;
        bit  ack;
        nstate = m_state;
        ncount = m_count;
        evt    = 0;
        ack    = bus.expired_ack;
        if (m_state == 0) begin
            if (bus.start) begin
                src = bus.load ? int'(bus.load_value) : m_count;
                if (src == 0) begin nstate = 3; ncount = 0; evt = 1; end
                else begin nstate = 1; ncount = src; end
            end else if (bus.load) begin
                ncount = bus.load_value;
            end
        end else if (m_state == 3) begin
            if (bus.start) begin
                src = bus.load ? int'(bus.load_value) : m_reload;
                nstate = 1; ncount = src; evt = (src == 0);
            end else begin
                if (bus.load) ncount = bus.load_value;
                if (ack) nstate = 0;
            end
        end else begin
            if (bus.stop) begin
                nstate = 0;
            end else if (bus.pause && (m_state == 2 || m_count != 0)) begin
                nstate = 2;
            end else if (m_count == 0) begin
                if (bus.auto_reload) begin nstate = 1; ncount = m_reload; evt = (m_reload == 0); end
                else nstate = 3;
            end else begin
                nstate = 1; ncount = m_count - 1; evt = (ncount == 0);
            end
        end
        m_ovr   = (evt && m_exp && !ack) || (m_ovr && !ack);
        m_exp   = evt || (m_exp && !ack);
        m_tc    = evt;
        m_state = nstate;
        m_count = ncount;
        if (bus.load) m_reload = bus.load_value;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit seen;
        tests    = 0;
        failures = 0;
        clear_n  = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // load, lv, start, stop, pause, auto, ack | count, busy, tc, expired, overrun
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1, 0, 0, 1, 0,  2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].load, int'(vecs[i].lv), vecs[i].start, vecs[i].stop, vecs[i].pause,
                  vecs[i].auto_r, vecs[i].ack);
            step();
            check($sformatf("vec%0d", i), int'(vecs[i].c), vecs[i].b, vecs[i].t, vecs[i].e,
                  vecs[i].o);
        end

        // Full-range countdown from the reset count with no load
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        check("start_from_reset", 15, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (bus.count != 0 && n < 40) begin
            step();
            n++;
        end
        check_int("cycles_to_zero", n, 15);
        check("zero_reached", 0, 1, 1, 1, 0);

        // Asynchronous reset in the middle of a countdown
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (bus.count != 8 && n < 40) begin
            step();
            n++;
        end
        check_int("cycles_to_eight", n, 7);
        #2;
        clear_n = 1'b0;
        #1;
        check("async_reset_mid", 15, 0, 0, 0, 0);
        @(negedge clk);
        clear_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tc_pulse || bus.busy || bus.count != 15) seen = 1;
        end
        check_int("abandoned_stays_idle", int'(seen), 0);

        // First edge after release must accept load+start
        do_reset();
        drive(1, 3, 1, 0, 0, 0, 0);
        step();
        check("first_edge_after_release", 3, 1, 0, 0, 0);

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            bus.load        = ($urandom_range(0, 7) == 0);
            bus.load_value  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2))
                                                          : 4'($urandom_range(0, 15));
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.stop        = ($urandom_range(0, 19) == 0);
            bus.pause       = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) bus.auto_reload = ~bus.auto_reload;
            bus.expired_ack = ($urandom_range(0, 9) == 0);
            model_step();
            step();
            check($sformatf("rand%0d", cyc), m_count, (m_state == 1 || m_state == 2), m_tc,
                  m_exp, m_ovr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 4, sets the count and load-value width in bits.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset is asynchronous and active-low, on port clear_n.
REQ-004 clear_n  in  1  asynchronous active-low reset.
REQ-005 load  in  1  capture load_value into the reload register.
REQ-006 load_value  in  WIDTH  terminal-count start value.
REQ-007 start  in  1  begin or restart a countdown.
REQ-008 stop  in  1  abort the countdown and return to IDLE.
REQ-009 pause  in  1  level; freeze the countdown while high.
REQ-010 auto_reload  in  1  level; reload and continue on expiry instead of stopping.
REQ-011 expired_ack  in  1  acknowledge and clear expired and overrun.
REQ-012 count  out  WIDTH  current count value, registered.
REQ-013 busy  out  1  high in RUN or PAUSED.
REQ-014 tc_pulse  out  1  one-cycle pulse, high in the cycle count==0 is first presented.
REQ-015 expired  out  1  sticky expiry flag, held until expired_ack.
REQ-016 overrun  out  1  sticky; an expiry occurred while expired was already high.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, PAUSED, DONE.
REQ-018 IDLE or DONE, load=1: reload_reg and count SHALL take load_value next cycle.
REQ-019 RUN or PAUSED, load=1: reload_reg SHALL update, count unaffected; the new value applies at the next reload or start.
REQ-020 IDLE, start=1:
- count source is load_value if load=1 the same cycle, else the current count.
- Source != 0: next state RUN, count = source.
- Source == 0: next state DONE, expired=1, tc_pulse=1 next cycle.
REQ-021 RUN, pause=0: count SHALL decrement by 1 per cycle; count never wraps below 0.
REQ-022 Value L, start at edge N: count==0 with tc_pulse=1 SHALL appear L cycles after edge N.
REQ-023 RUN reaching 0 with auto_reload=0: next state DONE, expired set, count held at 0.
REQ-024 RUN reaching 0 with auto_reload=1:
- expired set; state stays RUN.
- count SHALL take reload_reg the following cycle.
- Period is reload_reg+1 cycles.
- auto_reload is sampled in the cycle count==0.
REQ-025 Expiry while expired=1 and expired_ack=0 SHALL set overrun.
REQ-026 RUN, pause=1: next state PAUSED, count frozen; PAUSED with pause=0 returns to RUN.
REQ-027 PAUSED: start SHALL be ignored.
REQ-028 stop=1 in RUN or PAUSED: next state IDLE, count held; stop has priority over pause, start and expiry.
REQ-029 DONE, expired_ack=1, start=0: next state IDLE, count remains 0.
REQ-030 DONE, start=1: count SHALL take reload_reg and state go RUN; expired stays unless acked the same cycle.
REQ-031 expired_ack SHALL clear expired and overrun in any state; a same-cycle expiry sets both and wins over the clear.
REQ-032 tc_pulse SHALL never be high two consecutive cycles, except with reload_reg=0 in auto-reload mode, where it SHALL be continuous.
REQ-033 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-034 clear_n=0 SHALL immediately force:
- state IDLE;
- count and reload_reg to all ones;
- busy, tc_pulse, expired and overrun to 0.
REQ-035 Reset mid-countdown SHALL abandon the countdown; no tc_pulse is produced afterwards.
REQ-036 On clear_n release the block SHALL accept load or start on the first rising edge.

Verification
REQ-037 WIDTH=4:
- Reset, then load_value=5 with load+start together.
- Required: count 5,4,3,2,1,0; tc_pulse at 0; expired=1; busy=0; DONE.
REQ-038 WIDTH=4, reload_reg=2, auto_reload=1, running:
- Required: count 2,1,0,2,1,0...; tc_pulse every 3 cycles.
- No ack given: overrun=1 at the second expiry.
REQ-039 WIDTH=4, count=7, running:
- pause for 3 cycles: count holds 7 throughout.
- Release pause: count resumes 6 next cycle.
- stop at count 4: IDLE with count 4, busy=0.
REQ-040 WIDTH=4: expired_ack in the same cycle as an auto-reload expiry -> expired stays 1.
REQ-041 WIDTH=4:
- Reset with no load: count=15.
- start: 15 cycles to count 0.
- Assert clear_n=0 at count 8: count=15 and IDLE immediately.
